// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: motion tick divider, serve/play/point/over FSM, scoring and direction.
// The ball datapath follows ball_center, ball_run, move_tick and dir_x, and reports ball_x and hit pulses.
module pong_game_ctrl #(
  parameter int TICK_DIV    = 5_000_000,
  parameter int SERVE_TICKS = 20,
  parameter int WIN_SCORE   = 5,
  parameter int GOAL_L      = 55,
  parameter int GOAL_R      = 570
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] ball_x,
  input  logic       hit_l,
  input  logic       hit_r,
  input  logic       btn1_n,
  input  logic       btn2_n,
  output logic       ball_center,
  output logic       ball_run,
  output logic       move_tick,
  output logic       dir_x,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SRV_W = $clog2(SERVE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_TICKS);
  localparam logic [3:0]       WIN      = 4'(WIN_SCORE);
  localparam logic [9:0]       GL       = 10'(GOAL_L);
  localparam logic [9:0]       GR       = 10'(GOAL_R);

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [SRV_W-1:0]   serve_cnt;
  logic               goal_l, goal_r, restart, serve_entry;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  // Registered tick: the first strobe appears TICK_DIV clocks after reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  assign goal_l      = (ball_x <= GL);
  assign goal_r      = (ball_x >= GR);
  // The loser restarts: only the button of the player who did not win counts.
  assign restart     = (state == OVER) && (winner ? !btn1_n : !btn2_n);
  assign serve_entry = (state_nxt == SERVE) && (state != SERVE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    ball_run  = 1'b0;
    unique case (state)
      IDLE:  if (!btn1_n || !btn2_n) state_nxt = SERVE;
      SERVE: if (serve_cnt == SRV_LAST) state_nxt = PLAY;
      PLAY: begin
        ball_run = 1'b1;
        if (goal_l || goal_r) state_nxt = POINT;
      end
      POINT: state_nxt = (score1 == WIN || score2 == WIN) ? OVER : SERVE;
      OVER:  if (restart) state_nxt = SERVE;
      default: state_nxt = IDLE;
    endcase
    move_tick = tick & ball_run;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ball_center <= 1'b0;
      serve_cnt   <= '0;
      dir_x       <= 1'b0;
      score1      <= 4'd0;
      score2      <= 4'd0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      ball_center <= serve_entry;
      if (serve_entry)
        serve_cnt <= '0;
      else if (state == SERVE && tick && serve_cnt != SRV_LAST)
        serve_cnt <= serve_cnt + 1'b1;

      unique case (state)
        PLAY: begin
          // Goals outrank paddle hits; a double hit leaves the direction alone.
          if (goal_l) begin
            score1 <= sat_inc(score1);
            dir_x  <= 1'b1;
          end else if (goal_r) begin
            score2 <= sat_inc(score2);
            dir_x  <= 1'b0;
          end else if (hit_l && !hit_r) begin
            dir_x <= 1'b0;
          end else if (hit_r && !hit_l) begin
            dir_x <= 1'b1;
          end
        end
        POINT: begin
          if (state_nxt == OVER) begin
            game_over <= 1'b1;
            winner    <= (score1 != WIN);
          end
        end
        OVER: begin
          if (restart) begin
            score1    <= 4'd0;
            score2    <= 4'd0;
            game_over <= 1'b0;
            dir_x     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
